// File: rtl/rename_freelist.sv
// Multi-port physical-register free list for rename: circular buffer with
// speculative head, committed head and tail; flush rewinds head in one cycle.
module rename_freelist #(
   parameter int PHYS_REGS      = 64,
   parameter int ARCH_REGS      = 32,
   parameter int POP_WIDTH      = 2,
   parameter int PUSH_WIDTH     = 2,
   parameter int PHYS_REG_WIDTH = $clog2(PHYS_REGS),
   localparam int DEPTH         = PHYS_REGS - ARCH_REGS,
   localparam int IW            = $clog2(DEPTH),
   localparam int PW            = IW + 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [POP_WIDTH-1:0]                     i_pop_req,
   output logic                                     o_pop_ready,
   output logic [POP_WIDTH-1:0][PHYS_REG_WIDTH-1:0] o_pop_reg,
   input  logic [POP_WIDTH-1:0]                     i_commit_alloc,
   input  logic [PUSH_WIDTH-1:0]                    i_push_en,
   input  logic [PUSH_WIDTH-1:0][PHYS_REG_WIDTH-1:0] i_push_reg,
   input  logic                                     i_flush,
   output logic [PW-1:0]                            o_free_count,
   output logic                                     o_overflow
);

   logic [PHYS_REG_WIDTH-1:0] r_entry [DEPTH];
   logic [PW-1:0]             r_head, r_commit_head, r_tail;
   logic                      r_overflow;

   logic [PW-1:0]                  w_free, w_n_pop, w_n_push, w_n_commit;
   logic [POP_WIDTH-1:0][PW-1:0]   w_pop_off;
   logic [PUSH_WIDTH-1:0][PW-1:0]  w_push_off;
   logic                           w_pop_fire, w_push_ovf;

   // Prefix popcounts compact the active lanes onto consecutive entries.
   always_comb begin
      w_n_pop    = '0;
      w_n_push   = '0;
      w_n_commit = '0;
      w_pop_off  = '0;
      w_push_off = '0;
      for (int i = 0; i < POP_WIDTH; i++) begin
         w_pop_off[i] = w_n_pop;
         w_n_pop      = w_n_pop + PW'(i_pop_req[i]);
         w_n_commit   = w_n_commit + PW'(i_commit_alloc[i]);
      end
      for (int j = 0; j < PUSH_WIDTH; j++) begin
         w_push_off[j] = w_n_push;
         w_n_push      = w_n_push + PW'(i_push_en[j]);
      end
   end

   assign w_free       = r_tail - r_head;
   assign o_free_count = w_free;
   assign o_pop_ready  = !i_flush && (w_free >= w_n_pop);
   assign w_pop_fire   = o_pop_ready && (|i_pop_req);
   assign w_push_ovf   = ({1'b0, w_free} + {1'b0, w_n_push}) > (PW+1)'(DEPTH);
   assign o_overflow   = r_overflow;

   always_comb begin
      for (int i = 0; i < POP_WIDTH; i++)
         o_pop_reg[i] = r_entry[IW'(r_head + w_pop_off[i])];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++)
            r_entry[k] <= PHYS_REG_WIDTH'(ARCH_REGS + k);
         r_head        <= '0;
         r_commit_head <= '0;
         r_tail        <= PW'(DEPTH);
         r_overflow    <= 1'b0;
      end else begin
         r_commit_head <= r_commit_head + w_n_commit;
         // Flush folds in a same-cycle commit so nothing committed is reissued.
         if (i_flush)
            r_head <= r_commit_head + w_n_commit;
         else if (w_pop_fire)
            r_head <= r_head + w_n_pop;
         if (|i_push_en) begin
            if (w_push_ovf) begin
               r_overflow <= 1'b1;
            end else begin
               for (int j = 0; j < PUSH_WIDTH; j++)
                  if (i_push_en[j])
                     r_entry[IW'(r_tail + w_push_off[j])] <= i_push_reg[j];
               r_tail <= r_tail + w_n_push;
            end
         end
      end
   end

endmodule

// File: tb/tb_rename_freelist.sv
// Directed bench for rename_freelist: reset, lane compaction, all-or-nothing,
// wrap-around against a reference queue, flush rewind and sticky overflow.
module tb_rename_freelist;
   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      pop_req, commit_alloc, push_en;
   logic            pop_ready, flush, overflow;
   logic [1:0][5:0] pop_reg, push_reg;
   logic [5:0]      free_count;

   int total = 0;
   int bad   = 0;

   rename_freelist dut (
      .clk(clk), .rst(rst),
      .i_pop_req(pop_req), .o_pop_ready(pop_ready), .o_pop_reg(pop_reg),
      .i_commit_alloc(commit_alloc), .i_push_en(push_en), .i_push_reg(push_reg),
      .i_flush(flush), .o_free_count(free_count), .o_overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pop_req = '0; commit_alloc = '0; push_en = '0; flush = 1'b0;
      push_reg[0] = '0; push_reg[1] = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   int q[$];
   int np, npu, k;
   logic [1:0] pr, pe;
   logic exp_rdy;

   initial begin
      rst = 1'b1;
      idle();
      tick();
      tick();

      // reset state and dual-lane pop
      do_reset();
      chk("rst_free", free_count, 32);
      chk("rst_ovf", overflow, 0);
      pop_req = 2'b11; #1;
      chk("rst_rdy", pop_ready, 1);
      chk("rst_pop0", pop_reg[0], 32);
      chk("rst_pop1", pop_reg[1], 33);
      tick(); idle(); #1;
      chk("rst_free2", free_count, 30);

      // sparse lanes compact to lowest free entry
      do_reset();
      pop_req = 2'b10; #1;
      chk("sparse_pop1", pop_reg[1], 32);
      tick();
      pop_req = 2'b01; #1;
      chk("sparse_pop0", pop_reg[0], 33);
      tick(); idle(); #1;
      chk("sparse_free", free_count, 30);

      // all-or-nothing at free_count=1
      do_reset();
      pop_req = 2'b11;
      repeat (15) tick();
      pop_req = 2'b01;
      tick(); idle(); #1;
      chk("aon_free1", free_count, 1);
      pop_req = 2'b11; #1;
      chk("aon_rdy0", pop_ready, 0);
      tick(); idle(); #1;
      chk("aon_free_hold", free_count, 1);
      pop_req = 2'b01; #1;
      chk("aon_rdy1", pop_ready, 1);
      chk("aon_last", pop_reg[0], 63);
      tick(); idle(); #1;
      chk("aon_empty", free_count, 0);

      // wrap: push 3,4 into the empty list, then pop them back
      push_en = 2'b11; push_reg[0] = 6'd3; push_reg[1] = 6'd4; #1;
      chk("wrap_no_bypass", pop_ready, 1);
      tick(); idle(); #1;
      chk("wrap_free2", free_count, 2);
      pop_req = 2'b11; #1;
      chk("wrap_pop0", pop_reg[0], 3);
      chk("wrap_pop1", pop_reg[1], 4);
      tick(); idle(); #1;
      chk("wrap_free0", free_count, 0);

      // several full wraps against a reference queue
      q.delete();
      for (int c = 0; c < 400; c++) begin
         pr = 2'($urandom_range(0, 3));
         pe = 2'($urandom_range(0, 3));
         if (c < 40) pr = 2'b00;
         np  = int'(pr[0]) + int'(pr[1]);
         npu = int'(pe[0]) + int'(pe[1]);
         if (q.size() + npu > 32) begin pe = 2'b00; npu = 0; end
         pop_req = pr; push_en = pe;
         push_reg[0] = 6'($urandom_range(0, 63));
         push_reg[1] = 6'($urandom_range(0, 63));
         #1;
         exp_rdy = (q.size() >= np);
         chk("q_rdy", pop_ready, exp_rdy);
         chk("q_free", free_count, q.size());
         if (exp_rdy) begin
            k = 0;
            for (int i = 0; i < 2; i++)
               if (pr[i]) begin chk("q_pop", pop_reg[i], q[k]); k++; end
         end
         tick();
         if (exp_rdy) repeat (np) void'(q.pop_front());
         for (int j = 0; j < 2; j++)
            if (pe[j]) q.push_back(int'(push_reg[j]));
      end
      idle(); #1;
      chk("q_ovf", overflow, 0);

      // flush rewinds head to committed head plus same-cycle commit
      do_reset();
      pop_req = 2'b11;
      repeat (3) tick();
      idle(); commit_alloc = 2'b11;
      tick();
      idle(); flush = 1'b1; commit_alloc = 2'b01; pop_req = 2'b11; #1;
      chk("fl_rdy0", pop_ready, 0);
      tick(); idle(); #1;
      chk("fl_free", free_count, 29);
      pop_req = 2'b01; #1;
      chk("fl_pop", pop_reg[0], 35);
      tick(); idle();

      // overflow is sticky, and the rejected push leaves tail and entries alone
      do_reset();
      push_en = 2'b01; push_reg[0] = 6'd5;
      tick(); idle(); #1;
      chk("ov_set", overflow, 1);
      chk("ov_free", free_count, 32);
      pop_req = 2'b11; #1;
      chk("ov_pop0", pop_reg[0], 32);
      chk("ov_pop1", pop_reg[1], 33);
      tick(); idle(); #1;
      chk("ov_free2", free_count, 30);
      repeat (3) tick();
      chk("ov_sticky", overflow, 1);
      do_reset();
      chk("ov_clr", overflow, 0);
      chk("ov_clr_free", free_count, 32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
